// File: rtl/b1_pkg.sv
// ----------------------------------------------------------------------------
// b1_pkg
// Shared definitions for the B1 sliding-window front end.
//   DW      : ECG sample width in bits
//   KERNEL  : window width. Fixed at 4, one output lane per tap.
//   SCNT_W  : width of the per-frame sample counter
//   WCNT_W  : width of the per-frame window counter and of win_idx
//   state_t : FSM encoding, also driven out on the debug state port
//   n_win() : number of windows in a frame of frame_len samples at a stride
// ----------------------------------------------------------------------------
package b1_pkg;

    localparam int DW     = 7;
    localparam int KERNEL = 4;
    localparam int SCNT_W = 11;
    localparam int WCNT_W = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        SLIDE = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // Count of complete windows: the first window needs KERNEL samples and
    // each later window needs STRIDE more. Trailing samples that cannot
    // complete a window are not counted.
    function automatic int n_win(input int frame_len, input int stride);
        return (frame_len - KERNEL) / stride + 1;
    endfunction

endpackage

// File: rtl/b1_tap_shift.sv
// ----------------------------------------------------------------------------
// b1_tap_shift
// DEPTH x W shift register. Each enabled cycle moves every tap one place
// toward tap 0 and loads i_din into the top tap.
//
// o_shifted is the combinational value the taps take on at the next enabled
// edge. It already contains i_din, so the parent can capture a complete
// window on the same edge that accepts the window's last sample.
//
// Ports
//   clk        in   clock
//   rst_n_2    in   asynchronous active-low reset, clears all taps
//   i_en       in   shift enable (one accepted sample)
//   i_din      in   W   incoming sample
//   o_shifted  out  DEPTH x W  taps after this cycle's shift, oldest in [0]
// ----------------------------------------------------------------------------
module b1_tap_shift
    import b1_pkg::*;
#(
    parameter int W     = DW,
    parameter int DEPTH = KERNEL
) (
    input  logic                      clk,
    input  logic                      rst_n_2,
    input  logic                      i_en,
    input  logic [W-1:0]              i_din,
    output logic [DEPTH-1:0][W-1:0]   o_shifted
);

    logic [DEPTH-1:0][W-1:0] r_taps;
    logic [DEPTH-1:0][W-1:0] w_shifted;

    always_comb begin
        w_shifted = r_taps;
        for (int i = 0; i < DEPTH - 1; i++) begin
            w_shifted[i] = r_taps[i+1];
        end
        w_shifted[DEPTH-1] = i_din;
    end

    always_ff @(posedge clk or negedge rst_n_2) begin
        if (!rst_n_2) begin
            r_taps <= '0;
        end else if (i_en) begin
            r_taps <= w_shifted;
        end
    end

    assign o_shifted = w_shifted;

endmodule

// File: rtl/b1_slide_window_gen.sv
// ----------------------------------------------------------------------------
// b1_slide_window_gen
// Turns one fixed-length frame of ECG samples into KERNEL-wide windows. Each
// window starts STRIDE samples after the previous one. A window is presented
// on four registered lanes, oldest sample on lane 0, for the B1
// capture/convolution stage.
//
// Ports
//   clk             in   clock
//   rst_n_2         in   asynchronous active-low reset
//   start           in   one-cycle pulse. Starts a frame from IDLE and is
//                        ignored at all other times.
//   din             in   DW   input sample
//   din_valid       in   din qualifies
//   din_ready       out  sample accepted this cycle if din_valid
//   slide_data_0..3 out  DW   window taps, oldest on lane 0
//   slide_valid     out  window on the lanes is valid
//   slide_ready     in   downstream accepts the window
//   win_idx         out  10   index of the presented window
//   busy            out  high whenever the FSM is not IDLE
//   frame_done      out  one-cycle pulse after the frame's last window is gone
//   o_dbg_state     out  current FSM state
//
// Handshakes (both sides): a transfer happens on a rising clock edge where
// valid && ready. A valid producer holds its data stable until that edge.
// din_ready is high only in FILL/SLIDE when the output register is empty or is
// being emptied this cycle. That gives full throughput, and a sample that
// completes a window can never overwrite an untaken window.
// ----------------------------------------------------------------------------
module b1_slide_window_gen
    import b1_pkg::*;
#(
    parameter int STRIDE    = 4,
    parameter int FRAME_LEN = 1804
) (
    input  logic              clk,
    input  logic              rst_n_2,
    input  logic              start,
    input  logic [DW-1:0]     din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic [DW-1:0]     slide_data_0,
    output logic [DW-1:0]     slide_data_1,
    output logic [DW-1:0]     slide_data_2,
    output logic [DW-1:0]     slide_data_3,
    output logic              slide_valid,
    input  logic              slide_ready,
    output logic [WCNT_W-1:0] win_idx,
    output logic              busy,
    output logic              frame_done,
    output state_t            o_dbg_state
);

    localparam int N_WIN = n_win(FRAME_LEN, STRIDE);
    // k_cnt only ever holds 0..STRIDE-1, and STRIDE <= KERNEL.
    localparam int KW    = $clog2(KERNEL);

    localparam logic [SCNT_W-1:0] S_KERNEL = SCNT_W'(KERNEL);
    localparam logic [SCNT_W-1:0] S_FRAME  = SCNT_W'(FRAME_LEN);
    localparam logic [SCNT_W-1:0] S_ONE    = SCNT_W'(1);
    localparam logic [WCNT_W-1:0] W_NWIN   = WCNT_W'(N_WIN);
    localparam logic [WCNT_W-1:0] W_ONE    = WCNT_W'(1);
    localparam logic [KW-1:0]     K_LAST   = KW'(STRIDE - 1);
    localparam logic [KW-1:0]     K_ONE    = KW'(1);

    // ---------------- state and datapath registers ----------------
    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [SCNT_W-1:0]         r_s_cnt;
    logic [KW-1:0]             r_k_cnt;
    logic [WCNT_W-1:0]         r_w_cnt;
    logic [KERNEL-1:0][DW-1:0] r_win;
    logic                      r_slide_valid;
    logic [WCNT_W-1:0]         r_win_idx;
    logic                      r_frame_done;

    // ---------------- combinational control ----------------
    logic                      w_out_free;
    logic                      w_din_ready;
    logic                      w_accept;
    logic [SCNT_W-1:0]         w_s_cnt_inc;
    logic                      w_last_sample;
    logic                      w_fill_done;
    logic                      w_stride_hit;
    logic                      w_emit;
    logic                      w_xfer;
    logic                      w_done_set;
    logic                      w_frame_start;
    logic [KERNEL-1:0][DW-1:0] w_shifted;

    assign w_out_free    = !r_slide_valid || slide_ready;
    assign w_din_ready   = ((r_state == FILL) || (r_state == SLIDE)) && w_out_free;
    assign w_accept      = din_valid && w_din_ready;
    assign w_xfer        = r_slide_valid && slide_ready;
    assign w_frame_start = (r_state == IDLE) && start;

    assign w_s_cnt_inc   = r_s_cnt + S_ONE;
    assign w_last_sample = w_accept && (w_s_cnt_inc == S_FRAME);

    // First window: the accept that brings the sample count to KERNEL.
    assign w_fill_done   = (r_state == FILL) && w_accept && (w_s_cnt_inc == S_KERNEL);
    // Later windows: every STRIDE-th accept in SLIDE. Once N_WIN windows have
    // been emitted, further stride hits are tail samples and are dropped.
    assign w_stride_hit  = (r_state == SLIDE) && w_accept && (r_k_cnt == K_LAST);
    assign w_emit        = w_fill_done || (w_stride_hit && (r_w_cnt < W_NWIN));

    b1_tap_shift #(
        .W     (DW),
        .DEPTH (KERNEL)
    ) u_tap_shift (
        .clk       (clk),
        .rst_n_2   (rst_n_2),
        .i_en      (w_accept),
        .i_din     (din),
        .o_shifted (w_shifted)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n_2) begin
        if (!rst_n_2) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done_set  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = FILL;
                end
            end
            FILL: begin
                // A frame no longer than KERNEL goes straight to DRAIN.
                if (w_last_sample) begin
                    w_state_nxt = DRAIN;
                end else if (w_fill_done) begin
                    w_state_nxt = SLIDE;
                end
            end
            SLIDE: begin
                if (w_last_sample) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // Finish once the last window has left or is leaving now.
                if (w_out_free) begin
                    w_done_set  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ---------------- counters ----------------
    always_ff @(posedge clk or negedge rst_n_2) begin
        if (!rst_n_2) begin
            r_s_cnt <= '0;
            r_k_cnt <= '0;
            r_w_cnt <= '0;
        end else if (w_frame_start) begin
            r_s_cnt <= '0;
            r_k_cnt <= '0;
            r_w_cnt <= '0;
        end else if (w_accept) begin
            r_s_cnt <= w_s_cnt_inc;
            if (r_state == SLIDE) begin
                r_k_cnt <= w_stride_hit ? '0 : (r_k_cnt + K_ONE);
            end
            if (w_emit) begin
                r_w_cnt <= r_w_cnt + W_ONE;
            end
        end
    end

    // ---------------- output register ----------------
    // The window is captured from the post-shift taps, so it appears one cycle
    // after the accept of its last sample. A new load and the transfer of the
    // previous window can share a cycle, and the load wins.
    always_ff @(posedge clk or negedge rst_n_2) begin
        if (!rst_n_2) begin
            r_win         <= '0;
            r_slide_valid <= 1'b0;
            r_win_idx     <= '0;
        end else if (w_emit) begin
            r_win         <= w_shifted;
            r_slide_valid <= 1'b1;
            r_win_idx     <= r_w_cnt;
        end else if (w_xfer) begin
            r_slide_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n_2) begin
        if (!rst_n_2) begin
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_done_set;
        end
    end

    assign din_ready    = w_din_ready;
    assign slide_data_0 = r_win[0];
    assign slide_data_1 = r_win[1];
    assign slide_data_2 = r_win[2];
    assign slide_data_3 = r_win[3];
    assign slide_valid  = r_slide_valid;
    assign win_idx      = r_win_idx;
    assign busy         = (r_state != IDLE);
    assign frame_done   = r_frame_done;
    assign o_dbg_state  = r_state;

endmodule

// File: doc/b1_slide_window_gen.md
Name: b1_slide_window_gen

Overview:
- Upstream producer of the four 7-bit Slide_Data lanes consumed by the B1 capture/convolution stage.
- Accepts one ECG sample stream of a fixed-length frame.
- Builds KERNEL-wide windows advancing by STRIDE and presents each window on four parallel lanes with a valid/ready handshake.
- Counts samples and windows, and flags end of frame.

Parameters:
- DW, 7, sample width in bits.
- KERNEL, 4, window width; fixed to 4 (one lane per tap).
- STRIDE, 4, samples between successive windows; legal range 1..KERNEL.
- FRAME_LEN, 1804, samples per frame.
- N_WIN, (FRAME_LEN-KERNEL)/STRIDE+1, windows per frame (451 with defaults); localparam.

Ports:
- clk  in  1  clock
- rst_n_2  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a frame when IDLE
- din  in  DW  input sample
- din_valid  in  1  din qualifies
- din_ready  out  1  block accepts din this cycle
- slide_data_0..slide_data_3  out  DW each  window taps, oldest sample on lane 0
- slide_valid  out  1  window on lanes is valid
- slide_ready  in  1  downstream accepts window
- win_idx  out  10  index of presented window, 0..N_WIN-1
- busy  out  1  high outside IDLE
- frame_done  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset rst_n_2, asynchronous, active-low; clock clk.
- Reset values: all outputs 0; tap shift register and counters cleared; state IDLE.
- Reset mid-frame discards all state. No window is emitted after release until a new start.
- Handshakes:
  - Input accepted on din_valid && din_ready.
  - Output transfers on slide_valid && slide_ready.
  - din_ready = (state in FILL, SLIDE) && (!slide_valid || slide_ready), which gives full-throughput pass-through.
- slide_data_*, slide_valid and win_idx are registered. While slide_valid && !slide_ready they hold stable.
- Tap register: on each accept, shift left (tap0 <= tap1 ... tap3 <= din).
- States:
  - IDLE: din_ready=0. start -> FILL; clear sample count s_cnt, stride count k_cnt, window count w_cnt. start while busy is ignored.
  - FILL: accept samples. On the accept that makes s_cnt==KERNEL, load the window into the output regs, slide_valid<=1, win_idx<=0, -> SLIDE.
  - SLIDE: per accept k_cnt++. When k_cnt reaches STRIDE-1 on an accept, emit the next window (win_idx=w_cnt) and reset k_cnt. After window N_WIN-1 is emitted, remaining samples up to FRAME_LEN are still accepted but produce no window (tail drop). When s_cnt==FRAME_LEN -> DRAIN.
  - DRAIN: din_ready=0. When slide_valid==0, or the last window transfers this cycle: pulse frame_done, -> IDLE.
- Latency: a window appears one cycle after the accept of its last sample.
- Simultaneous events: a new window load and transfer of the previous window in the same cycle are legal. With STRIDE=1 this sustains one window per cycle.
- Counters: s_cnt 11 bits, w_cnt 10 bits; no wrap within a frame.
- din_valid in IDLE/DRAIN is ignored (not consumed).

Decomposition:
- Shared package b1_pkg: DW, KERNEL, and the window-count function (FRAME_LEN-KERNEL)/STRIDE+1.
- Also in b1_pkg: the state encoding IDLE=0, FILL=1, SLIDE=2, DRAIN=3.
- One natural sub-module: b1_tap_shift (KERNEL x DW shift register with enable, parallel out).
- FSM, counters and output register stay in the top.

Test Plan:
- Ramp frame din=n mod 128, n=0..1803, valid and ready always high, defaults -> 451 windows.
  - Window w = {4w, 4w+1, 4w+2, 4w+3} mod 128.
  - win_idx 0..450.
  - frame_done exactly once, one cycle after the last window.
- STRIDE=1, FRAME_LEN=10, ramp 0..9 -> 7 windows {0,1,2,3}..{6,7,8,9} on consecutive cycles; the first appears the cycle after sample 3 is accepted.
- slide_ready low for 5 cycles at window 2 -> lanes and win_idx held; din_ready=0 during the stall; no sample lost or duplicated.
- FRAME_LEN=1806, STRIDE=4 -> 451 windows. The last 2 samples are accepted but dropped; frame_done after s_cnt=1806.
- Reset:
  - rst_n_2 asserted mid-SLIDE -> all outputs 0 immediately; after release, no output until start.
  - Then a fresh frame reproduces the first-test results.
- start pulses while busy are ignored; din_valid toggled randomly -> windows are identical to the gap-free run.
